// File: rtl/apb_pkg.sv
// Shared APB definitions for the 16-bit address / 8-bit data I/O bus.
// Used by the initiator and by future APB responders.
package apb_pkg;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_init_state_e;

  typedef struct packed {
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic                  write;
  } apb_req_t;

endpackage

// File: rtl/apb_initiator.sv
// Single-outstanding APB initiator: valid/ready request -> SETUP/ACCESS -> response.
// Optional ACCESS timeout enabled by defining APB_INITIATOR_TIMEOUT_EN.
module apb_initiator
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [APB_ADDR_W-1:0] req_addr,
  input  logic [APB_DATA_W-1:0] req_wdata,
  input  logic                  req_write,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [APB_ADDR_W-1:0] apb_if_paddr,
  output logic [APB_DATA_W-1:0] apb_if_pwdata,
  output logic                  apb_if_pwrite,
  output logic                  apb_if_psel,
  output logic                  apb_if_penable,
  input  logic [APB_DATA_W-1:0] apb_if_prdata,
  input  logic                  apb_if_pready
);

  apb_init_state_e state;
  apb_init_state_e state_nxt;
  apb_req_t        req_q;
  logic            accept;
  logic            done;
  logic            expire;

  assign accept = (state == IDLE) && req_valid && req_ready;
  assign done   = (state == ACCESS) && apb_if_pready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = SETUP;
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        if (done || expire) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Handshake and APB strobes are registered decodes of the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      apb_if_psel    <= 1'b0;
      apb_if_penable <= 1'b0;
      rsp_valid      <= 1'b0;
    end else begin
      state          <= state_nxt;
      req_ready      <= (state_nxt == IDLE);
      apb_if_psel    <= (state_nxt == SETUP) ||
                        (state_nxt == ACCESS);
      apb_if_penable <= (state_nxt == ACCESS);
      rsp_valid      <= (state_nxt == RESP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= '0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        req_q.addr  <= req_addr;
        req_q.wdata <= req_wdata;
        req_q.write <= req_write;
      end
      if (done) begin
        rsp_rdata <= req_q.write ? '0 : apb_if_prdata;
      end else if (expire) begin
        rsp_rdata <= '1;
      end
    end
  end

  assign apb_if_paddr  = req_q.addr;
  assign apb_if_pwdata = req_q.wdata;
  assign apb_if_pwrite = req_q.write;

`ifdef APB_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             err_q;

  // Expiry fires on the last permitted wait cycle; pready then wins
  assign expire = (state == ACCESS) && !apb_if_pready &&
                  (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == SETUP) begin
        cnt <= '0;
      end else if ((state == ACCESS) && !apb_if_pready) begin
        cnt <= cnt + 1'b1;
      end
      if (done) begin
        err_q <= 1'b0;
      end else if (expire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign rsp_error = err_q;
`else
  assign expire    = 1'b0;
  assign rsp_error = 1'b0;
`endif

endmodule
